// File: rtl/ex4_nibble_packer.sv
// ex4_nibble_packer: collects 4-bit gate-stage results into words and queues
// the finished words in a small FIFO for a valid/ready consumer.
// Optional feature: define EX4_PARITY_EN to add out_par. It is the XOR of all
// word bits, computed when the word is pushed and stored with each FIFO entry.
module ex4_nibble_packer #(
  parameter int NIB_W         = 4,
  parameter int NIBS_PER_WORD = 4,
  parameter int OUT_DEPTH     = 2,
  localparam int WORD_W       = NIB_W * NIBS_PER_WORD,
  localparam int CNT_W        = $clog2(NIBS_PER_WORD + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NIB_W-1:0]  in_y,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_cnt
`ifdef EX4_PARITY_EN
  ,
  output logic              out_par
`endif
);

  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int FC_W  = $clog2(OUT_DEPTH + 2);

  // Collector state
  logic [CNT_W-1:0]  k;
  logic [WORD_W-1:0] col_data;

  // A completed word waits here for one edge before entering the FIFO.
  // This gives the two-edge accept-to-out_valid latency.
  logic              pend_valid;
  logic [WORD_W-1:0] pend_data;
  logic [CNT_W-1:0]  pend_cnt;

  // FIFO storage. The head entry is also mirrored into the output registers.
  logic [WORD_W-1:0] mem_data [OUT_DEPTH];
  logic [CNT_W-1:0]  mem_cnt  [OUT_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [FC_W-1:0]   fifo_count;

`ifdef EX4_PARITY_EN
  logic pend_par;
  logic mem_par [OUT_DEPTH];
  logic head_par;
`endif

  logic              accept, pop, push, complete;
  logic [WORD_W-1:0] word_next;
  logic [FC_W-1:0]   count_next, occ_next;
  logic [PTR_W-1:0]  rd_next, wr_next;
  logic              head_bypass;
  logic [WORD_W-1:0] head_data;
  logic [CNT_W-1:0]  head_cnt;

  // Transfer decode, next occupancy and the next head-of-FIFO value
  always_comb begin
    accept    = in_valid & in_ready;
    pop       = out_valid & out_ready;
    push      = pend_valid;
    complete  = accept & ((k == CNT_W'(NIBS_PER_WORD - 1)) | in_last);
    word_next = col_data | (WORD_W'(in_y) << (NIB_W * int'(k)));

    count_next = fifo_count + FC_W'(push) - FC_W'(pop);
    occ_next   = count_next + FC_W'(complete);

    rd_next = rd_ptr;
    if (pop) rd_next = (rd_ptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
    wr_next = (wr_ptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;

    // A word pushed into a FIFO that is empty after this pop becomes the head.
    // That entry is being written on this same edge, so it is taken directly
    // from the pending register.
    head_bypass = push && ((fifo_count - FC_W'(pop)) == '0);
    head_data   = head_bypass ? pend_data : mem_data[rd_next];
    head_cnt    = head_bypass ? pend_cnt  : mem_cnt[rd_next];
`ifdef EX4_PARITY_EN
    head_par    = head_bypass ? pend_par  : mem_par[rd_next];
`endif
  end

  // Collector: place each accepted nibble at slot k and hand off finished words
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k          <= '0;
      col_data   <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      pend_cnt   <= '0;
`ifdef EX4_PARITY_EN
      pend_par   <= 1'b0;
`endif
    end else begin
      pend_valid <= complete;
      if (accept) begin
        if (complete) begin
          pend_data <= word_next;
          pend_cnt  <= k + 1'b1;
`ifdef EX4_PARITY_EN
          pend_par  <= ^word_next;
`endif
          col_data  <= '0;
          k         <= '0;
        end else begin
          col_data <= word_next;
          k        <= k + 1'b1;
        end
      end
    end
  end

  // FIFO storage writes; the contents are only read behind fifo_count
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= pend_data;
      mem_cnt[wr_ptr]  <= pend_cnt;
`ifdef EX4_PARITY_EN
      mem_par[wr_ptr]  <= pend_par;
`endif
    end
  end

  // FIFO pointers, registered head outputs and registered in_ready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_cnt    <= '0;
`ifdef EX4_PARITY_EN
      out_par    <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr <= wr_next;
      rd_ptr     <= rd_next;
      fifo_count <= count_next;
      in_ready   <= (occ_next < FC_W'(OUT_DEPTH));
      out_valid  <= (count_next != '0);
      if (count_next != '0) begin
        out_data <= head_data;
        out_cnt  <= head_cnt;
`ifdef EX4_PARITY_EN
        out_par  <= head_par;
`endif
      end
    end
  end

endmodule
